// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer in front of a single-port RAM.
// The winner's command is registered onto the RAM port. Reads carry a
// {valid, id} tag down a latency-matched pipe, so the response is steered
// back to the requester that issued the read.
module ram_port_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1   // edges from the RAM sampling addr to dout valid (1..4)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_valid,
  output logic          m0_ready,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_valid,
  output logic          m1_ready,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  // prio_q = 0: requester 0 wins a tie; 1: requester 1 wins a tie
  logic          prio_q, prio_d;
  logic          gnt0, gnt1;
  logic          rd_issue;

  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;

  // Tag pipe: RD_LAT stages, followed by the per-requester rvalid register,
  // giving 1+RD_LAT stages in total from issue to response.
  logic [RD_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT-1:0] tag_id_q, tag_id_d;
  logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DW-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  // Grant selection and priority pointer update
  always_comb begin
    gnt0   = m0_valid && (!m1_valid || !prio_q);
    gnt1   = m1_valid && (!m0_valid ||  prio_q);
    prio_d = prio_q;
    if (gnt0)      prio_d = 1'b1;
    else if (gnt1) prio_d = 1'b0;
  end

  assign m0_ready = gnt0;
  assign m1_ready = gnt1;
  assign rd_issue = (gnt0 && !m0_we) || (gnt1 && !m1_we);

  // Next RAM port command: winner's fields, or idle with addr/din held
  always_comb begin
    ram_we_d   = 1'b0;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    if (gnt0) begin
      ram_we_d   = m0_we;
      ram_addr_d = m0_addr;
      ram_din_d  = m0_wdata;
    end else if (gnt1) begin
      ram_we_d   = m1_we;
      ram_addr_d = m1_addr;
      ram_din_d  = m1_wdata;
    end
  end

  // Tag shift and response steering; rdata keeps the last delivered word
  always_comb begin
    tag_vld_d[0] = rd_issue;
    tag_id_d[0]  = gnt1;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    rvalid0_d = tag_vld_q[RD_LAT-1] && !tag_id_q[RD_LAT-1];
    rvalid1_d = tag_vld_q[RD_LAT-1] &&  tag_id_q[RD_LAT-1];
    rdata0_d  = rvalid0_q ? ram_dout : rdata0_q;
    rdata1_d  = rvalid1_q ? ram_dout : rdata1_q;
  end

  // All state registers; reset clears port, pointer and in-flight tags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  // RAM dout is only valid in the response cycle itself, so the data word is
  // passed through then and held from the register afterwards.
  assign m0_rdata  = rvalid0_q ? ram_dout : rdata0_q;
  assign m1_rdata  = rvalid1_q ? ram_dout : rdata1_q;

endmodule
